// File: rtl/eth_tx_pkg.sv
// Shared types and defaults for the Ethernet TX ping-pong frame buffer.
package eth_tx_pkg;

   localparam int DEPTH_DEF      = 2048;
   localparam int START_HOLD_DEF = 4;

   typedef enum logic [7:0] {
      T_IDLE      = 8'h01,
      T_START     = 8'h02,
      T_WAIT_BUSY = 8'h04,
      T_WAIT_DONE = 8'h08
   } tx_state_e;

endpackage

// File: rtl/eth_tx_bank_ram.sv
// Two-bank frame store: simple dual-port RAM, one write port, one registered read port.
module eth_tx_bank_ram #(
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = $clog2(2 * DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem [0:2*DEPTH-1];

   // No reset on the array or read register so the tools can map this to block RAM.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/eth_tx_frame_buffer.sv
// Ping-pong TX frame buffer feeding the RGMII transmitter.
// Optional frame statistics outputs are enabled with `define ETH_TX_BUF_STATS_EN.
//
// state       | meaning
// T_IDLE      | waiting for a full read bank and transmitter not busy
// T_START     | holding o_eth_tx_start high for START_HOLD cycles
// T_WAIT_BUSY | waiting for the transmitter to raise busy
// T_WAIT_DONE | waiting for busy to fall, then release the bank
module eth_tx_frame_buffer
   import eth_tx_pkg::*;
#(
   parameter int DEPTH      = DEPTH_DEF,
   parameter int START_HOLD = START_HOLD_DEF
) (
   input  logic        i_eth_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_tx_data,
   input  logic        i_tx_valid,
   input  logic        i_tx_last,
   output logic        o_tx_ready,
   input  logic [15:0] i_eth_mem_rd_addr,
   output logic [7:0]  o_eth_data_out_8b,
   output logic [15:0] o_eth_tx_size,
   output logic        o_eth_tx_start,
   input  logic        i_eth_tx_busy,
   output logic        o_overflow
`ifdef ETH_TX_BUF_STATS_EN
   ,
   output logic [31:0] o_frames_sent,
   output logic [31:0] o_frames_dropped
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int HW = $clog2(START_HOLD);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [16:0]   DEPTH_EXT = 17'(DEPTH);
   localparam logic [HW-1:0] HOLD_INIT = HW'(START_HOLD - 1);

   logic [1:0]    full_q, full_d;
   logic          wr_bank_q, rd_bank_q, rdy_q, ovf_q, mask_q;
   logic [AW:0]   wr_cnt_q;
   logic [AW:0]   len_q [2];
   tx_state_e     state_q;
   logic [HW-1:0] hold_q;
   logic          start_q;
   logic [15:0]   size_q;
   logic [7:0]    ram_rdata;

   logic accept, in_range, wr_en, commit, drop_end, bank_rel;

   assign o_tx_ready = rdy_q && !full_q[wr_bank_q];
   assign accept     = i_tx_valid && o_tx_ready;
   assign in_range   = !wr_cnt_q[AW];
   assign wr_en      = accept && in_range;
   assign commit     = wr_en && i_tx_last;
   assign drop_end   = accept && !in_range && i_tx_last;
   assign bank_rel   = (state_q == T_WAIT_DONE) && !i_eth_tx_busy;

   // Commit and release always hit different banks, so both can apply in one cycle.
   always_comb begin
      full_d = full_q;
      if (bank_rel) full_d[rd_bank_q] = 1'b0;
      if (commit)   full_d[wr_bank_q] = 1'b1;
   end

   always_ff @(posedge i_eth_clk or posedge i_rst) begin
      if (i_rst) begin
         rdy_q     <= 1'b0;
         full_q    <= 2'b00;
         wr_bank_q <= 1'b0;
         wr_cnt_q  <= '0;
         len_q[0]  <= '0;
         len_q[1]  <= '0;
         ovf_q     <= 1'b0;
      end else begin
         rdy_q  <= 1'b1;
         full_q <= full_d;
         if (accept) begin
            if (in_range) begin
               if (i_tx_last) begin
                  len_q[wr_bank_q] <= wr_cnt_q + CNT_ONE;
                  wr_bank_q        <= ~wr_bank_q;
                  wr_cnt_q         <= '0;
               end else begin
                  wr_cnt_q <= wr_cnt_q + CNT_ONE;
               end
            end else begin
               // Counter parks at DEPTH and discards until the frame's last byte.
               ovf_q <= 1'b1;
               if (i_tx_last) wr_cnt_q <= '0;
            end
         end
      end
   end

   always_ff @(posedge i_eth_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= T_IDLE;
         start_q   <= 1'b0;
         size_q    <= '0;
         hold_q    <= '0;
         rd_bank_q <= 1'b0;
      end else begin
         case (state_q)
            T_IDLE: begin
               if (full_q[rd_bank_q] && !i_eth_tx_busy) begin
                  size_q  <= 16'(len_q[rd_bank_q]);
                  start_q <= 1'b1;
                  hold_q  <= HOLD_INIT;
                  state_q <= T_START;
               end
            end
            T_START: begin
               if (hold_q == '0) begin
                  start_q <= 1'b0;
                  state_q <= T_WAIT_BUSY;
               end else begin
                  hold_q <= hold_q - HW'(1);
               end
            end
            T_WAIT_BUSY: begin
               if (i_eth_tx_busy) state_q <= T_WAIT_DONE;
            end
            T_WAIT_DONE: begin
               if (!i_eth_tx_busy) begin
                  rd_bank_q <= ~rd_bank_q;
                  state_q   <= T_IDLE;
               end
            end
            default: begin
               start_q <= 1'b0;
               state_q <= T_IDLE;
            end
         endcase
      end
   end

   // Zero-fill beyond the frame so the transmitter's padding reads as 0x00.
   always_ff @(posedge i_eth_clk or posedge i_rst) begin
      if (i_rst) begin
         mask_q <= 1'b1;
      end else begin
         mask_q <= ({1'b0, i_eth_mem_rd_addr} >= 17'(len_q[rd_bank_q])) ||
                   ({1'b0, i_eth_mem_rd_addr} >= DEPTH_EXT);
      end
   end

   eth_tx_bank_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (AW + 1)
   ) u_ram (
      .clk   (i_eth_clk),
      .we    (wr_en),
      .waddr ({wr_bank_q, wr_cnt_q[AW-1:0]}),
      .wdata (i_tx_data),
      .raddr ({rd_bank_q, i_eth_mem_rd_addr[AW-1:0]}),
      .rdata (ram_rdata)
   );

   assign o_eth_data_out_8b = mask_q ? 8'h00 : ram_rdata;
   assign o_eth_tx_size     = size_q;
   assign o_eth_tx_start    = start_q;
   assign o_overflow        = ovf_q;

`ifdef ETH_TX_BUF_STATS_EN
   logic [31:0] sent_q, dropped_q;

   always_ff @(posedge i_eth_clk or posedge i_rst) begin
      if (i_rst) begin
         sent_q    <= '0;
         dropped_q <= '0;
      end else begin
         if (bank_rel) sent_q    <= sent_q + 32'd1;
         if (drop_end) dropped_q <= dropped_q + 32'd1;
      end
   end

   assign o_frames_sent    = sent_q;
   assign o_frames_dropped = dropped_q;
`endif

endmodule
